lvds_rx_align_ctrl: RTL

Word-alignment sequencer for one lvds_rx_9chan_6x receiver instance. It watches the deserialized frame-clock channel (the fclk slice of rx_out) and pulses rx_data_align (bitslip) until that word equals the expected frame pattern. It then declares alignment for the 8 data channels and monitors for loss of framing. One instance per receiver, clocked by that receiver's rx_outclock.

---
 rtl/lvds_rx_align_ctrl_if.sv | 30 +++
 rtl/lvds_rx_align_ctrl.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/lvds_rx_align_ctrl_if.sv
// Handshake bundle between lvds_rx_align_ctrl and one lvds_rx_9chan_6x receiver.
//   rx_locked     receiver PLL lock, synchronous to rx_clk
//   fclk_word     deserialized frame-clock channel, one word per cycle
//   realign       single-cycle request to restart acquisition
//   rx_data_align bitslip strobe to the receiver
//   aligned       framing valid, data channels usable
//   align_err     acquisition failed (sticky)
//   slip_cnt      slips issued in the current acquisition (saturating)
// master: the alignment controller; slave: the receiver side.
interface lvds_rx_align_ctrl_if #(
   parameter int unsigned DESER = 6
) ();
   logic             rx_locked;
   logic [DESER-1:0] fclk_word;
   logic             realign;
   logic             rx_data_align;
   logic             aligned;
   logic             align_err;
   logic [3:0]       slip_cnt;

   modport master (
      input  rx_locked, fclk_word, realign,
      output rx_data_align, aligned, align_err, slip_cnt
   );

   modport slave (
      output rx_locked, fclk_word, realign,
      input  rx_data_align, aligned, align_err, slip_cnt
   );
endinterface

// File: rtl/lvds_rx_align_ctrl.sv
// Word-alignment sequencer for one LVDS receiver. Watches the registered frame-clock word and
// issues bitslip pulses until it equals FCLK_PATTERN, then flags alignment and monitors framing.
// Ports:
//   i_rx_clk  receiver rx_outclock, all logic on its rising edge
//   i_reset   asynchronous active-high reset
//   if_rx     lvds_rx_align_ctrl_if.master (lock/word/realign in, bitslip/status out)
module lvds_rx_align_ctrl #(
   parameter int unsigned      DESER              = 6,
   parameter logic [DESER-1:0] FCLK_PATTERN       = 6'b111000,
   parameter int unsigned      ALIGN_PULSE_CYCLES = 2,
   parameter int unsigned      SETTLE_CYCLES      = 4,
   parameter int unsigned      LOCK_COUNT         = 16,
   parameter int unsigned      MAX_SLIPS          = 12
) (
   input logic                   i_rx_clk,
   input logic                   i_reset,
   lvds_rx_align_ctrl_if.master  if_rx
);

   localparam logic [7:0] PULSE_LAST  = 8'(ALIGN_PULSE_CYCLES - 1);
   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
   localparam logic [7:0] LOCK_LAST   = 8'(LOCK_COUNT - 1);
   localparam logic [3:0] SLIP_LIMIT  = 4'(MAX_SLIPS);

   typedef enum logic [2:0] {
      StIdle, StCheck, StSlip, StSettle, StLocked, StError
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [DESER-1:0] r_fclk_word;
   logic [7:0]       r_timer;
   logic [7:0]       r_match_cnt;
   logic [3:0]       r_slip_cnt;
   logic             r_rx_data_align;
   logic             r_aligned;
   logic             r_align_err;

   logic w_match;
   logic w_lock_hit;
   logic w_restart;
   logic w_rx_data_align_nxt;
   logic w_aligned_nxt;
   logic w_align_err_nxt;

   assign w_match    = (r_fclk_word == FCLK_PATTERN);
   assign w_lock_hit = (r_match_cnt == LOCK_LAST);
   // realign restarts acquisition from any state except IDLE, but only while locked
   assign w_restart  = if_rx.rx_locked && if_rx.realign && (r_state != StIdle);

   // State register
   always_ff @(posedge i_rx_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; lock loss beats realign, which beats the word comparison
   always_comb begin
      w_state_nxt = r_state;
      if (!if_rx.rx_locked) begin
         w_state_nxt = StIdle;
      end else if (w_restart) begin
         w_state_nxt = StCheck;
      end else begin
         unique case (r_state)
            StIdle:   w_state_nxt = StCheck;
            StCheck: begin
               if (w_match) begin
                  if (w_lock_hit) w_state_nxt = StLocked;
               end else if (r_slip_cnt == SLIP_LIMIT) begin
                  w_state_nxt = StError;
               end else begin
                  w_state_nxt = StSlip;
               end
            end
            StSlip:   if (r_timer == PULSE_LAST)  w_state_nxt = StSettle;
            StSettle: if (r_timer == SETTLE_LAST) w_state_nxt = StCheck;
            StLocked: if (!w_match)               w_state_nxt = StCheck;
            StError:  w_state_nxt = StError;
            default:  w_state_nxt = StIdle;
         endcase
      end
   end

   // Output decode; outputs are registered from these so they change with the state register
   always_comb begin
      w_rx_data_align_nxt = (w_state_nxt == StSlip);
      // aligned rises one cycle after entering LOCKED and drops with the exit
      w_aligned_nxt       = (r_state == StLocked) && (w_state_nxt == StLocked);
      w_align_err_nxt     = (w_state_nxt == StError);
   end

   // Input stage, counters and registered outputs
   always_ff @(posedge i_rx_clk or posedge i_reset) begin
      if (i_reset) begin
         r_fclk_word     <= '0;
         r_timer         <= '0;
         r_match_cnt     <= '0;
         r_slip_cnt      <= '0;
         r_rx_data_align <= 1'b0;
         r_aligned       <= 1'b0;
         r_align_err     <= 1'b0;
      end else begin
         r_fclk_word <= if_rx.fclk_word;

         // Timer runs only while dwelling in SLIP or SETTLE
         if ((w_state_nxt != r_state) || !(r_state inside {StSlip, StSettle})) begin
            r_timer <= '0;
         end else begin
            r_timer <= r_timer + 8'd1;
         end

         if (w_restart || (w_state_nxt inside {StIdle, StSlip, StSettle, StError}) ||
             ((r_state == StLocked) && (w_state_nxt == StCheck))) begin
            r_match_cnt <= '0;
         end else if ((r_state == StCheck) && w_match && (r_match_cnt != 8'hFF)) begin
            r_match_cnt <= r_match_cnt + 8'd1;
         end

         if (w_restart || (w_state_nxt == StIdle) ||
             ((r_state == StLocked) && (w_state_nxt == StCheck))) begin
            r_slip_cnt <= '0;
         end else if ((r_state == StCheck) && (w_state_nxt == StSlip) &&
                      (r_slip_cnt != 4'hF)) begin
            r_slip_cnt <= r_slip_cnt + 4'd1;
         end

         r_rx_data_align <= w_rx_data_align_nxt;
         r_aligned       <= w_aligned_nxt;
         r_align_err     <= w_align_err_nxt;
      end
   end

   assign if_rx.rx_data_align = r_rx_data_align;
   assign if_rx.aligned       = r_aligned;
   assign if_rx.align_err     = r_align_err;
   assign if_rx.slip_cnt      = r_slip_cnt;

endmodule
